// File: rtl/save_pkg.sv
// save_pkg: shared states and constants for the save RAM upload path
package save_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, WAIT, HOLD} state_t;
  localparam int HSC_SIZE = 2048;
  localparam logic [7:0] FILL_BYTE = 8'hFF;
  localparam logic [1:0] NONE = 2'd0;
  localparam logic [1:0] HSC = 2'd1;
  localparam logic [1:0] SAVEKEY = 2'd2;
endpackage

// File: rtl/save_ram_uploader_if.sv
// save_ram_uploader_if: hps_io ioctl upload handshake
interface save_ram_uploader_if;
  logic ioctl_upload;
  logic ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0] ioctl_din;
  logic ioctl_din_valid;
  modport master (output ioctl_upload, ioctl_rd, ioctl_addr, input ioctl_din, ioctl_din_valid);
  modport slave (input ioctl_upload, ioctl_rd, ioctl_addr, output ioctl_din, ioctl_din_valid);
endinterface

// File: rtl/save_idle_timer.sv
// save_idle_timer: quiet-period counter that fires one autosave request after CPU writes stop
module save_idle_timer #(
  parameter logic [23:0] IDLE_CYCLES = 24'd14_000_000
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic reload,
  input  logic restart,
  input  logic count_en,
  output logic pulse
);
  logic [23:0] cnt;
  logic armed;
  // Reload on writes/completion, count down while idle and dirty, fire once at zero.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cnt <= IDLE_CYCLES;
      armed <= 1'b0;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      if (reload) begin
        cnt <= IDLE_CYCLES;
        armed <= 1'b1;
      end else if (restart) cnt <= IDLE_CYCLES;
      else if (count_en) begin
        if (cnt != 24'd0) cnt <= cnt - 24'd1;
        else if (armed) begin
          pulse <= 1'b1;
          armed <= 1'b0;
        end
      end
    end
  end
endmodule

// File: rtl/save_ram_uploader.sv
// save_ram_uploader: streams cart NVRAM to the HPS over ioctl upload; SAVE_AUTOSAVE_EN adds autosave_req
module save_ram_uploader
  import save_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int SAVE_SIZE = HSC_SIZE
`ifdef SAVE_AUTOSAVE_EN
  ,
  parameter logic [23:0] IDLE_CYCLES = 24'd14_000_000
`endif
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic enable,
  save_ram_uploader_if.slave io,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [7:0] ram_q,
  output logic ram_sel,
  input  logic cpu_we,
  output logic save_pending,
  output logic upload_done
`ifdef SAVE_AUTOSAVE_EN
  ,
  output logic autosave_req
`endif
);
  state_t state, state_n;
  logic oor, start, launch, in_range, done;
  // Next state and request decode; a request launches only from IDLE or HOLD.
  always_comb begin
    start = enable & io.ioctl_upload & io.ioctl_rd;
    in_range = io.ioctl_addr < 25'(SAVE_SIZE);
    state_n = state;
    case (state)
      IDLE: state_n = start ? FETCH : IDLE;
      FETCH: state_n = WAIT;
      WAIT: state_n = HOLD;
      HOLD: state_n = !io.ioctl_upload ? IDLE : io.ioctl_rd ? FETCH : HOLD;
      default: state_n = IDLE;
    endcase
    if (!enable) state_n = IDLE;
    launch = (state == IDLE || state == HOLD) && state_n == FETCH;
    done = enable && state == WAIT && !oor && ram_addr == ADDR_W'(SAVE_SIZE - 1);
  end
  // State, RAM ownership, returned byte and dirty tracking; CPU writes always win over completion.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state <= IDLE;
      oor <= 1'b0;
      ram_addr <= '0;
      ram_sel <= 1'b0;
      io.ioctl_din <= 8'h00;
      io.ioctl_din_valid <= 1'b0;
      upload_done <= 1'b0;
      save_pending <= 1'b0;
    end else begin
      state <= state_n;
      upload_done <= done;
      save_pending <= enable & (cpu_we | (save_pending & !upload_done));
      ram_sel <= launch ? in_range : ram_sel & (state_n != IDLE);
      io.ioctl_din_valid <= enable & ((state == WAIT) | (io.ioctl_din_valid & !launch));
      if (launch) oor <= !in_range;
      if (launch && in_range) ram_addr <= io.ioctl_addr[ADDR_W-1:0];
      if (state == WAIT) io.ioctl_din <= oor ? FILL_BYTE : ram_q;
    end
  end
`ifdef SAVE_AUTOSAVE_EN
  save_idle_timer #(.IDLE_CYCLES(IDLE_CYCLES)) u_timer (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .reload   ((enable & cpu_we) | upload_done),
    .restart  (launch),
    .count_en (save_pending & (state == IDLE)),
    .pulse    (autosave_req)
  );
`endif
endmodule

// File: tb/tb_save_ram_uploader.sv
// tb_save_ram_uploader: scoreboard bench for save_ram_uploader (define SAVE_AUTOSAVE_EN for the autosave test)
module tb_save_ram_uploader;
  import save_pkg::*;
  logic clk_sys = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b1;
  logic cpu_we = 1'b0;
  logic [10:0] ram_addr;
  logic [7:0] ram_q = 8'h00;
  logic ram_sel, save_pending, upload_done;
`ifdef SAVE_AUTOSAVE_EN
  logic autosave_req;
`endif
  logic [7:0] mem [2048];
  logic [7:0] exp_q [$];
  int compared = 0;
  int mismatched = 0;
  int done_cnt = 0;
  logic sel_seen = 1'b0;

  save_ram_uploader_if bus ();

  save_ram_uploader #(
    .ADDR_W(11),
    .SAVE_SIZE(2048)
`ifdef SAVE_AUTOSAVE_EN
    ,
    .IDLE_CYCLES(24'd100)
`endif
  ) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .enable       (enable),
    .io           (bus),
    .ram_addr     (ram_addr),
    .ram_q        (ram_q),
    .ram_sel      (ram_sel),
    .cpu_we       (cpu_we),
    .save_pending (save_pending),
    .upload_done  (upload_done)
`ifdef SAVE_AUTOSAVE_EN
    ,
    .autosave_req (autosave_req)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  // NVRAM model with one-cycle read latency.
  always @(posedge clk_sys) ram_q <= mem[ram_addr];

  // Count completion pulses and note any RAM ownership, sampled mid-cycle.
  always @(negedge clk_sys) begin
    if (upload_done === 1'b1) done_cnt++;
    if (ram_sel === 1'b1) sel_seen = 1'b1;
  end

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic end_session;
    bus.ioctl_upload = 1'b0;
    bus.ioctl_rd = 1'b0;
    tick;
    tick;
  endtask

  task automatic cpu_write(input logic [10:0] a, input logic [7:0] d);
    mem[a] = d;
    cpu_we = 1'b1;
    tick;
    cpu_we = 1'b0;
  endtask

  task automatic rd_byte(input logic [24:0] a, input logic exp_done, input logic we_at_end);
    int lat;
    logic [7:0] e;
    exp_q.push_back(a < 25'd2048 ? mem[a[10:0]] : 8'hFF);
    bus.ioctl_addr = a;
    bus.ioctl_rd = 1'b1;
    tick;
    bus.ioctl_rd = 1'b0;
    lat = 1;
    while (bus.ioctl_din_valid !== 1'b1 && lat < 10) begin
      tick;
      lat++;
    end
    e = exp_q.pop_front();
    compared++;
    if (lat != 3) begin mismatched++; $display("FAIL rd_latency addr=%h: got %0d cycles want 3", a, lat); end
    compared++;
    if (bus.ioctl_din !== e) begin mismatched++; $display("FAIL rd_data addr=%h: got %h want %h", a, bus.ioctl_din, e); end
    compared++;
    if (upload_done !== exp_done) begin mismatched++; $display("FAIL rd_done addr=%h: got %b want %b", a, upload_done, exp_done); end
    cpu_we = we_at_end;
    tick;
    cpu_we = 1'b0;
    repeat (4) tick;
  endtask

  task automatic full_upload;
    int d0;
    d0 = done_cnt;
    bus.ioctl_upload = 1'b1;
    for (int i = 0; i < 2048; i++) rd_byte(25'(i), i == 2047, 1'b0);
    end_session;
    compared++;
    if (done_cnt - d0 != 1) begin mismatched++; $display("FAIL upload_done_count: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_reset;
    bus.ioctl_upload = 1'b0;
    bus.ioctl_rd = 1'b0;
    bus.ioctl_addr = '0;
    reset = 1'b1;
    repeat (3) tick;
    compared++;
    if (bus.ioctl_din !== 8'h00) begin mismatched++; $display("FAIL reset_din: got %h want 00", bus.ioctl_din); end
    compared++;
    if (bus.ioctl_din_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b want 0", bus.ioctl_din_valid); end
    compared++;
    if (ram_addr !== 11'd0) begin mismatched++; $display("FAIL reset_ram_addr: got %h want 000", ram_addr); end
    compared++;
    if (ram_sel !== 1'b0) begin mismatched++; $display("FAIL reset_ram_sel: got %b want 0", ram_sel); end
    compared++;
    if (save_pending !== 1'b0) begin mismatched++; $display("FAIL reset_save_pending: got %b want 0", save_pending); end
    compared++;
    if (upload_done !== 1'b0) begin mismatched++; $display("FAIL reset_upload_done: got %b want 0", upload_done); end
    reset = 1'b0;
    tick;
  endtask

  task automatic test_full_upload;
    full_upload;
  endtask

  task automatic test_rd_dropped;
    logic [7:0] e;
    bus.ioctl_upload = 1'b1;
    exp_q.push_back(mem[5]);
    bus.ioctl_addr = 25'd5;
    bus.ioctl_rd = 1'b1;
    tick;
    bus.ioctl_addr = 25'd6;
    tick;
    bus.ioctl_rd = 1'b0;
    tick;
    e = exp_q.pop_front();
    compared++;
    if (bus.ioctl_din_valid !== 1'b1) begin mismatched++; $display("FAIL dropped_valid: got %b want 1", bus.ioctl_din_valid); end
    compared++;
    if (bus.ioctl_din !== e) begin mismatched++; $display("FAIL dropped_data: got %h want %h", bus.ioctl_din, e); end
    repeat (3) tick;
    compared++;
    if (bus.ioctl_din_valid !== 1'b1) begin mismatched++; $display("FAIL dropped_hold_valid: got %b want 1", bus.ioctl_din_valid); end
    compared++;
    if (bus.ioctl_din !== e) begin mismatched++; $display("FAIL dropped_hold_data: got %h want %h", bus.ioctl_din, e); end
    end_session;
  endtask

  task automatic test_save_pending;
    compared++;
    if (save_pending !== 1'b0) begin mismatched++; $display("FAIL pending_initial: got %b want 0", save_pending); end
    cpu_write(11'h010, 8'hA7);
    compared++;
    if (save_pending !== 1'b1) begin mismatched++; $display("FAIL pending_set: got %b want 1", save_pending); end
    full_upload;
    compared++;
    if (save_pending !== 1'b0) begin mismatched++; $display("FAIL pending_cleared: got %b want 0", save_pending); end
    cpu_write(11'h020, 8'h3C);
    bus.ioctl_upload = 1'b1;
    rd_byte(25'd2047, 1'b1, 1'b1);
    end_session;
    compared++;
    if (save_pending !== 1'b1) begin mismatched++; $display("FAIL pending_we_wins: got %b want 1", save_pending); end
  endtask

  task automatic test_out_of_range;
    int d0;
    d0 = done_cnt;
    sel_seen = 1'b0;
    bus.ioctl_upload = 1'b1;
    rd_byte(25'd2048, 1'b0, 1'b0);
    rd_byte(25'h1FFFFFF, 1'b0, 1'b0);
    compared++;
    if (sel_seen !== 1'b0) begin mismatched++; $display("FAIL oor_ram_sel: got %b want 0", sel_seen); end
    end_session;
    compared++;
    if (done_cnt != d0) begin mismatched++; $display("FAIL oor_done: got %0d pulses want 0", done_cnt - d0); end
  endtask

  task automatic test_reset_in_wait;
    bus.ioctl_upload = 1'b1;
    bus.ioctl_addr = 25'd100;
    bus.ioctl_rd = 1'b1;
    tick;
    bus.ioctl_rd = 1'b0;
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    compared++;
    if (bus.ioctl_din !== 8'h00) begin mismatched++; $display("FAIL rstwait_din: got %h want 00", bus.ioctl_din); end
    compared++;
    if (bus.ioctl_din_valid !== 1'b0) begin mismatched++; $display("FAIL rstwait_valid: got %b want 0", bus.ioctl_din_valid); end
    compared++;
    if (ram_addr !== 11'd0) begin mismatched++; $display("FAIL rstwait_ram_addr: got %h want 000", ram_addr); end
    compared++;
    if (ram_sel !== 1'b0) begin mismatched++; $display("FAIL rstwait_ram_sel: got %b want 0", ram_sel); end
    compared++;
    if (save_pending !== 1'b0) begin mismatched++; $display("FAIL rstwait_pending: got %b want 0", save_pending); end
    compared++;
    if (upload_done !== 1'b0) begin mismatched++; $display("FAIL rstwait_done: got %b want 0", upload_done); end
    compared++;
    if (dut.state !== IDLE) begin mismatched++; $display("FAIL rstwait_state: got %0d want %0d", dut.state, IDLE); end
    tick;
    rd_byte(25'd100, 1'b0, 1'b0);
    end_session;
  endtask

  task automatic test_enable_off;
    enable = 1'b0;
    tick;
    sel_seen = 1'b0;
    bus.ioctl_upload = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.ioctl_addr = 25'(i * 700 + 5);
      bus.ioctl_rd = 1'b1;
      tick;
      bus.ioctl_rd = 1'b0;
      repeat (4) tick;
      compared++;
      if (bus.ioctl_din_valid !== 1'b0) begin mismatched++; $display("FAIL en_off_valid %0d: got %b want 0", i, bus.ioctl_din_valid); end
    end
    compared++;
    if (sel_seen !== 1'b0) begin mismatched++; $display("FAIL en_off_ram_sel: got %b want 0", sel_seen); end
    cpu_we = 1'b1;
    tick;
    cpu_we = 1'b0;
    tick;
    compared++;
    if (save_pending !== 1'b0) begin mismatched++; $display("FAIL en_off_pending: got %b want 0", save_pending); end
    end_session;
    enable = 1'b1;
    tick;
  endtask

`ifdef SAVE_AUTOSAVE_EN
  task automatic test_autosave;
    int n;
    cpu_we = 1'b1;
    tick;
    cpu_we = 1'b0;
    n = 0;
    while (autosave_req !== 1'b1 && n < 400) begin
      tick;
      n++;
    end
    compared++;
    if (n != 101) begin mismatched++; $display("FAIL autosave_delay: got %0d want 101", n); end
    tick;
    compared++;
    if (autosave_req !== 1'b0) begin mismatched++; $display("FAIL autosave_one_shot: got %b want 0", autosave_req); end
    cpu_we = 1'b1;
    tick;
    cpu_we = 1'b0;
    n = 0;
    while (autosave_req !== 1'b1 && n < 400) begin
      cpu_we = (n == 49);
      tick;
      n++;
    end
    cpu_we = 1'b0;
    compared++;
    if (n != 151) begin mismatched++; $display("FAIL autosave_rearm: got %0d want 151", n); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'(i) ^ 8'h5A;
    bus.ioctl_upload = 1'b0;
    bus.ioctl_rd = 1'b0;
    bus.ioctl_addr = '0;
    test_reset;
    test_full_upload;
    test_rd_dropped;
    test_save_pending;
    test_out_of_range;
    test_reset_in_wait;
    test_enable_off;
`ifdef SAVE_AUTOSAVE_EN
    test_autosave;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/save_ram_uploader.md
Name: save_ram_uploader

Overview:
- Streams the 2 KB High Score Cart NVRAM (cart_save=1) from its on-chip RAM back to the HPS over the hps_io ioctl upload handshake.
- This is the read-out counterpart of the cart/NVRAM download path.
- Tracks CPU writes to NVRAM, so the core raises a save request only when data has changed.
- Sits between the NVRAM spram read port, the 7800 CPU bus and hps_io.

Parameters:
- ADDR_W, 11, NVRAM address width in bits.
- SAVE_SIZE, 2048, number of bytes uploaded per session; must be ≤ 2**ADDR_W.
- IDLE_CYCLES, 24'd14_000_000, autosave quiet period in clk_sys cycles (optional feature only).

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous active-high reset
- enable  in  1  save cart present (cart_save==1); when 0 the block is held idle
- ioctl_upload  in  1  HPS upload session active
- ioctl_rd  in  1  one-cycle byte request from hps_io
- ioctl_addr  in  25  byte address of the current request
- ioctl_din  out  8  byte returned to hps_io
- ioctl_din_valid  out  1  ioctl_din holds the byte for the last request
- ram_addr  out  ADDR_W  NVRAM read address
- ram_q  in  8  NVRAM read data, 1-cycle latency
- ram_sel  out  1  block owns the NVRAM port (top muxes ram_addr in)
- cpu_we  in  1  CPU write strobe into NVRAM
- save_pending  out  1  NVRAM modified since last complete upload
- upload_done  out  1  one-cycle pulse when the last byte is delivered

Behaviour:
- Reset values: ioctl_din=0, ioctl_din_valid=0, ram_addr=0, ram_sel=0, save_pending=0, upload_done=0; FSM in IDLE.
- Reset mid-session aborts the session. save_pending clears on reset.
- FSM states: IDLE, FETCH, WAIT, HOLD.
- IDLE:
  - ram_sel=0.
  - Go to FETCH on ioctl_upload=1 & ioctl_rd=1 & enable=1.
  - On that transition, latch ram_addr=ioctl_addr[ADDR_W-1:0], set ram_sel=1, clear ioctl_din_valid.
- FETCH: one cycle for address to reach the RAM, then go to WAIT.
- WAIT:
  - Capture ioctl_din <= ram_q, set ioctl_din_valid=1, go to HOLD.
  - Latency from ioctl_rd to valid data is exactly 3 cycles.
- HOLD:
  - ioctl_din stays stable.
  - A new ioctl_rd goes to FETCH with the new address and clears valid.
  - ioctl_upload falling goes to IDLE.
- Upload completion:
  - If the delivered address == SAVE_SIZE-1, pulse upload_done in the WAIT→HOLD cycle.
  - upload_done clears save_pending unless cpu_we is asserted in the same cycle; cpu_we wins, and save_pending stays 1.
- Out-of-range requests (ioctl_addr ≥ SAVE_SIZE): no RAM access; ioctl_din=8'hFF with the same 3-cycle latency; no upload_done.
- Address wrap: only ioctl_addr[ADDR_W-1:0] is used after the range check; no wrap beyond SAVE_SIZE.
- ioctl_rd while in FETCH/WAIT: ignored. hps_io never issues one before valid; the bench checks it is dropped.
- enable=0: forces IDLE, ram_sel=0, save_pending=0; an ioctl_rd returns no data.
- cpu_we sets save_pending=1 whenever enable=1, in any state.
- An upload in progress does not block CPU writes.
- The top gates cpu_we with ram_sel to avoid port contention.

Optional Feature:
- Macro: SAVE_AUTOSAVE_EN.
- Defined:
  - Adds output autosave_req (1 bit, reset 0) and a 24-bit quiet counter.
  - The counter reloads to IDLE_CYCLES on every cpu_we and decrements while save_pending=1 and the FSM is in IDLE.
  - At 0 it pulses autosave_req for 1 cycle and holds at 0 until the next cpu_we or upload_done.
  - An upload starting resets the counter.
- Undefined: no counter and no autosave_req port; save_pending is the sole request.

Decomposition:
- Package save_pkg holds:
  - the state enum (IDLE, FETCH, WAIT, HOLD);
  - the HSC_SIZE=2048 constant;
  - the FILL_BYTE=8'hFF constant;
  - the cart_save code constants (NONE=0, HSC=1, SAVEKEY=2).
- One natural sub-module: save_idle_timer (the quiet counter), instantiated only under SAVE_AUTOSAVE_EN.

Test Plan:
- Preload RAM[0..2047]=addr[7:0]^8'h5A; run a full upload with rd every 8 cycles.
  - Required: each ioctl_din matches 3 cycles after rd.
  - Required: upload_done pulses once, at addr 2047.
- cpu_we at addr 0x10, then a full upload.
  - Required: save_pending 0→1, then 0 after upload_done.
  - Repeat with cpu_we coincident with upload_done: save_pending stays 1.
- Request ioctl_addr=2048 and 0x1FFFFFF.
  - Required: ioctl_din=8'hFF, valid after 3 cycles, no upload_done, ram_sel=0 throughout.
- Assert reset while in WAIT at addr 100.
  - Required: next cycle all outputs are at reset values and the FSM is in IDLE.
  - Required: a later rd at addr 100 returns the correct byte.
- enable=0 with ioctl_rd pulses.
  - Required: ioctl_din_valid stays 0, ram_sel=0, cpu_we does not set save_pending.
- SAVE_AUTOSAVE_EN with IDLE_CYCLES=100: cpu_we, then idle.
  - Required: autosave_req pulses exactly at cycle 101 after cpu_we.
  - Required: a second cpu_we at cycle 50 delays the pulse to cycle 151.
